sdram_read_ppfifo: RTL and testbench
====================================

Name: sdram_read_ppfifo

Overview:
- Ping-pong read buffer directly downstream of the SDRAM read sequencer.
- Write side: accepts 32-bit words from the sequencer into one of two banks, using the sequencer's activate/ready/size/starved handshake.
- Read side: presents completed banks to the wishbone slave in fill order, one word per strobe, all on the single SDRAM clock.

Parameters:
- DEPTH_LOG2, default 9: log2 of words per bank (512 words each).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- wr_reset  in  1  flush pulse from sequencer
- wr_activate  in  2  bank select from sequencer; one-hot or zero
- wr_ready  out  2  bank i empty and claimable
- wr_size  out  24  words per bank (2**DEPTH_LOG2), zero-extended
- wr_strobe  in  1  write pulse
- wr_data  in  32  write word
- starved  out  1  consumer waiting, no readable data
- rd_enable  in  1  consumer has a read transaction pending
- rd_available  out  1  a readable bank exists
- rd_strobe  in  1  pop one word
- rd_data  out  32  popped word
- rd_valid  out  1  rd_data valid this cycle

Behaviour:
- Reset: rst low at a clock edge forces the following, taking effect next cycle regardless of any operation in progress:
  - both banks EMPTY, counts 0, read pointer 0, fill_order 0
  - wr_ready=2'b11, rd_valid=0, rd_data=0, rd_available=0, starved=0
- wr_size is constant and combinational.
- Per-bank state machine: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY->FILLING: wr_activate[i] rises.
  - FILLING->FULL: wr_activate[i] falls and count>0.
  - FILLING->EMPTY: wr_activate[i] falls and count==0.
  - FULL->DRAINING: bank selected by the read side.
  - DRAINING->EMPTY: the last word is popped.
- wr_ready[i]: registered; 1 only in EMPTY. A bank leaving DRAINING at edge N shows wr_ready at N+1.
- Writes:
  - wr_strobe with exactly one FILLING bank stores wr_data at that bank's count; count increments; visible next cycle.
  - Write ignored if no bank is activated, both bits are set, or count==2**DEPTH_LOG2.
- Bank counts are DEPTH_LOG2+1 bits wide. Storage is 2 x 2**DEPTH_LOG2 x 32 synchronous RAM, one write port and one read port.
- fill_order:
  - Set to the bank index at each FILLING->FULL transition, pushed into a 2-entry order queue.
  - The read side always drains the queue head first. Bank 1 filled before bank 0 is drained first.
- Read:
  - rd_available = (head bank FULL or DRAINING) and words remaining > 0.
  - rd_strobe while rd_available: pops the word at the read pointer; rd_data/rd_valid appear at N+1 (1-cycle latency). Read pointer increments and wraps to 0 when the bank empties.
  - rd_strobe without rd_available: ignored, rd_valid=0.
  - Back-to-back strobes give one word per cycle, including across the bank boundary.
- starved = rd_enable && !rd_available, registered (1-cycle lag).
- wr_reset pulse (one cycle): same effect as rst next cycle, except rd_data holds its value. Takes priority over a simultaneous wr_strobe/rd_strobe.
- Simultaneous events:
  - The FILLING->FULL release of one bank and the DRAINING->EMPTY of the other in the same cycle both take effect.
  - A write into bank A and a read from bank B in the same cycle are both served.

Optional Feature:
- Macro: SDRAM_READ_PPFIFO_STATUS_EN.
- Defined: adds outputs overflow (1), underflow (1), bank_count0 (DEPTH_LOG2+1), bank_count1 (DEPTH_LOG2+1).
  - overflow sticks on a write dropped because the bank is full.
  - underflow sticks on rd_strobe without rd_available.
  - Both clear on rst or wr_reset.
- Undefined: ports absent; dropped writes and ignored strobes are silent; core behaviour identical.

Test Plan:
- Reset, then idle: wr_ready=2'b11, wr_size=24'd512, rd_available=0, starved=0; after rd_enable=1, starved=1 one cycle later.
- Activate bank 0, write 4 words 0xA0..0xA3, deassert activate: rd_available=1 next cycle; 4 consecutive rd_strobe give rd_data A0,A1,A2,A3 with 1-cycle lag; wr_ready[0] returns to 1.
- Fill bank 1 (0xB0,0xB1), then bank 0 (0xC0); drain all: order B0,B1,C0; back-to-back strobes show no gap at the bank switch.
- Write 513 words to bank 0: count saturates at 512; 513th word dropped; overflow=1 (STATUS_EN); drain yields 512 words in sequence.
- Bank 0 FULL, bank 1 FILLING with 3 words, then wr_reset pulse: next cycle wr_ready=2'b11, rd_available=0, further rd_strobe gives rd_valid=0.
- rst asserted mid-drain (2 of 4 words popped): next cycle all banks EMPTY, rd_valid=0, wr_ready=2'b11.

Source files
------------

// File: rtl/sdram_read_ppfifo.sv
// Ping-pong read buffer between the SDRAM read sequencer and the wishbone slave.
// Optional status outputs (overflow/underflow/bank counts) are enabled by SDRAM_READ_PPFIFO_STATUS_EN.
module sdram_read_ppfifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_reset,
    input  logic [1:0]            wr_activate,
    output logic [1:0]            wr_ready,
    output logic [23:0]           wr_size,
    input  logic                  wr_strobe,
    input  logic [31:0]           wr_data,
    output logic                  starved,
    input  logic                  rd_enable,
    output logic                  rd_available,
    input  logic                  rd_strobe,
    output logic [31:0]           rd_data,
    output logic                  rd_valid
`ifdef SDRAM_READ_PPFIFO_STATUS_EN
    ,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   bank_count0,
    output logic [DEPTH_LOG2:0]   bank_count1
`endif
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bankState_e;

    bankState_e        state_q [2];
    bankState_e        state_d [2];
    logic [CW-1:0]     count_q [2];
    logic [CW-1:0]     count_d [2];
    logic [CW-1:0]     rdPtr_q, rdPtr_d;
    logic [1:0]        orderQ_q, orderQ_d;
    logic [1:0]        orderCnt_q, orderCnt_d;
    logic [1:0]        actPrev_q;
    logic [1:0]        wrReady_q;
    logic              starved_q;
    logic              rdValid_q;
    logic [31:0]       rdData_q;
    logic [1:0]        bankRelease;

    logic [31:0]       mem [2*DEPTH];

    logic              clear;
    logic              head;
    logic [CW-1:0]     headCount;
    logic              readable;
    logic              pop;
    logic              lastPop;
    logic              fillOne;
    logic              wrBank;
    logic              actMatch;
    logic [CW-1:0]     wrCount;
    logic              wrFull;
    logic              doWrite;
    logic              dropFull;
    logic [DEPTH_LOG2:0] wrAddr;
    logic [DEPTH_LOG2:0] rdAddr;

    assign clear     = !rst || wr_reset;
    assign wr_size   = 24'(DEPTH);

    // The read side only ever looks at the oldest completed bank.
    assign head      = orderQ_q[0];
    assign headCount = count_q[head];
    assign readable  = (orderCnt_q != 2'd0)
                    && (state_q[head] == BANK_FULL || state_q[head] == BANK_DRAINING)
                    && (headCount != rdPtr_q);
    assign pop       = rd_strobe && readable;
    assign lastPop   = pop && ((rdPtr_q + CW'(1)) == headCount);

    assign fillOne   = (state_q[0] == BANK_FILLING) ^ (state_q[1] == BANK_FILLING);
    assign wrBank    = (state_q[1] == BANK_FILLING);
    assign actMatch  = (wr_activate == (wrBank ? 2'b10 : 2'b01));
    assign wrCount   = count_q[wrBank];
    assign wrFull    = (wrCount == CW'(DEPTH));
    assign doWrite   = wr_strobe && fillOne && actMatch && !wrFull;
    assign dropFull  = wr_strobe && fillOne && actMatch && wrFull;

    assign wrAddr    = {wrBank, wrCount[DEPTH_LOG2-1:0]};
    assign rdAddr    = {head, rdPtr_q[DEPTH_LOG2-1:0]};

    assign rd_available = readable;
    assign wr_ready     = wrReady_q;
    assign starved      = starved_q;
    assign rd_valid     = rdValid_q;
    assign rd_data      = rdData_q;

    // Bank lifecycle, word counts, read pointer and completion-order queue.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rdPtr_d     = rdPtr_q;
        orderQ_d    = orderQ_q;
        orderCnt_d  = orderCnt_q;
        bankRelease = 2'b00;

        for (int i = 0; i < 2; i++) begin
            case (state_q[i])
                BANK_EMPTY: begin
                    if (wr_activate[i] && !actPrev_q[i]) begin
                        state_d[i] = BANK_FILLING;
                    end
                end
                BANK_FILLING: begin
                    if (!wr_activate[i]) begin
                        if (count_q[i] != '0) begin
                            state_d[i]     = BANK_FULL;
                            bankRelease[i] = 1'b1;
                        end else begin
                            state_d[i] = BANK_EMPTY;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (doWrite) begin
            count_d[wrBank] = wrCount + CW'(1);
        end

        if (pop) begin
            rdPtr_d       = rdPtr_q + CW'(1);
            state_d[head] = BANK_DRAINING;
            if (lastPop) begin
                state_d[head] = BANK_EMPTY;
                count_d[head] = '0;
                rdPtr_d       = '0;
                orderQ_d[0]   = orderQ_q[1];
                orderCnt_d    = orderCnt_q - 2'd1;
            end
        end

        // Pushes happen after the pop so a release and a drain completion can share a cycle.
        for (int i = 0; i < 2; i++) begin
            if (bankRelease[i]) begin
                orderQ_d[orderCnt_d[0]] = 1'(i);
                orderCnt_d              = orderCnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= BANK_EMPTY;
                count_q[i] <= '0;
            end
            rdPtr_q    <= '0;
            orderQ_q   <= 2'b00;
            orderCnt_q <= 2'd0;
            actPrev_q  <= 2'b00;
            wrReady_q  <= 2'b11;
            starved_q  <= 1'b0;
            rdValid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= state_d[i];
                count_q[i]   <= count_d[i];
                wrReady_q[i] <= (state_q[i] == BANK_EMPTY);
            end
            rdPtr_q    <= rdPtr_d;
            orderQ_q   <= orderQ_d;
            orderCnt_q <= orderCnt_d;
            actPrev_q  <= wr_activate;
            starved_q  <= rd_enable && !readable;
            rdValid_q  <= pop;
        end
    end

    // rd_data survives a sequencer flush; only the system reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdData_q <= '0;
        end else if (!wr_reset && pop) begin
            rdData_q <= mem[rdAddr];
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrAddr] <= wr_data;
        end
    end

`ifdef SDRAM_READ_PPFIFO_STATUS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (dropFull) begin
                overflow_q <= 1'b1;
            end
            if (rd_strobe && !readable) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign bank_count0 = count_q[0];
    assign bank_count1 = count_q[1];
`endif

endmodule

// File: tb/tb_sdram_read_ppfifo.sv
// Directed self-checking bench for sdram_read_ppfifo; inputs change and outputs are sampled on the falling edge.
module tb_sdram_read_ppfifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_reset;
    logic [1:0]  wr_activate;
    logic [1:0]  wr_ready;
    logic [23:0] wr_size;
    logic        wr_strobe;
    logic [31:0] wr_data;
    logic        starved;
    logic        rd_enable;
    logic        rd_available;
    logic        rd_strobe;
    logic [31:0] rd_data;
    logic        rd_valid;
`ifdef SDRAM_READ_PPFIFO_STATUS_EN
    logic        overflow;
    logic        underflow;
    logic [9:0]  bank_count0;
    logic [9:0]  bank_count1;
`endif

    int testCount = 0;
    int failCount = 0;

    sdram_read_ppfifo #(.DEPTH_LOG2(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_reset     (wr_reset),
        .wr_activate  (wr_activate),
        .wr_ready     (wr_ready),
        .wr_size      (wr_size),
        .wr_strobe    (wr_strobe),
        .wr_data      (wr_data),
        .starved      (starved),
        .rd_enable    (rd_enable),
        .rd_available (rd_available),
        .rd_strobe    (rd_strobe),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid)
`ifdef SDRAM_READ_PPFIFO_STATUS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow),
        .bank_count0  (bank_count0),
        .bank_count1  (bank_count1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Claims a bank, writes n consecutive words from base, then releases it.
    task automatic fillBank(input int bank, input int n, input logic [31:0] base);
        wr_activate = (bank == 1) ? 2'b10 : 2'b01;
        tick();
        for (int k = 0; k < n; k++) begin
            wr_strobe = 1'b1;
            wr_data   = base + 32'(k);
            tick();
        end
        wr_strobe   = 1'b0;
        wr_activate = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_reset = 1'b0; wr_activate = 2'b00; wr_strobe = 1'b0;
        wr_data = '0; rd_enable = 1'b0; rd_strobe = 1'b0;
        tick(); tick();
        rst = 1'b1;
        testCount++;
        if (wr_ready !== 2'b11) begin failCount++; $display("[TB] FAIL reset_wr_ready got %b want 11", wr_ready); end
        testCount++;
        if (wr_size !== 24'd512) begin failCount++; $display("[TB] FAIL reset_wr_size got %0d want 512", wr_size); end
        testCount++;
        if (rd_available !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rd_available got %b want 0", rd_available); end
        testCount++;
        if (starved !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs got starved=%b valid=%b data=%h want 0/0/0", starved, rd_valid, rd_data);
        end
        rd_enable = 1'b1;
        testCount++;
        if (starved !== 1'b0) begin failCount++; $display("[TB] FAIL starved_lag got %b want 0", starved); end
        tick();
        testCount++;
        if (starved !== 1'b1) begin failCount++; $display("[TB] FAIL starved_set got %b want 1", starved); end
        rd_enable = 1'b0;
        tick();
    endtask

    task automatic test_single_bank();
        fillBank(0, 4, 32'hA0);
        testCount++;
        if (rd_available !== 1'b1) begin failCount++; $display("[TB] FAIL single_available got %b want 1", rd_available); end
        testCount++;
        if (wr_ready !== 2'b10) begin failCount++; $display("[TB] FAIL single_ready_busy got %b want 10", wr_ready); end
        rd_strobe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            testCount++;
            if (rd_valid !== 1'b1 || rd_data !== 32'hA0 + 32'(k)) begin
                failCount++;
                $display("[TB] FAIL single_word%0d got valid=%b data=%h want 1/%h", k, rd_valid, rd_data, 32'hA0 + 32'(k));
            end
        end
        rd_strobe = 1'b0;
        testCount++;
        if (rd_available !== 1'b0 || wr_ready !== 2'b10) begin
            failCount++;
            $display("[TB] FAIL single_drained got avail=%b ready=%b want 0/10", rd_available, wr_ready);
        end
        tick();
        testCount++;
        if (wr_ready !== 2'b11 || rd_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_ready_back got ready=%b valid=%b want 11/0", wr_ready, rd_valid);
        end
    endtask

    task automatic test_order();
        logic [31:0] expWords [3];
        expWords[0] = 32'hB0; expWords[1] = 32'hB1; expWords[2] = 32'hC0;
        fillBank(1, 2, 32'hB0);
        fillBank(0, 1, 32'hC0);
        rd_strobe = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            testCount++;
            if (rd_valid !== 1'b1 || rd_data !== expWords[k]) begin
                failCount++;
                $display("[TB] FAIL order_word%0d got valid=%b data=%h want 1/%h", k, rd_valid, rd_data, expWords[k]);
            end
        end
        rd_strobe = 1'b0;
        testCount++;
        if (rd_available !== 1'b0) begin failCount++; $display("[TB] FAIL order_empty got %b want 0", rd_available); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] expWords [4];
        expWords[0] = 32'hF0; expWords[1] = 32'hF1; expWords[2] = 32'h60; expWords[3] = 32'h61;
        fillBank(0, 2, 32'hF0);
        wr_activate = 2'b10;
        tick();
        wr_strobe = 1'b1; wr_data = 32'h60;
        tick();
        // write into bank 1 and pop from bank 0 in the same cycle
        wr_data = 32'h61; rd_strobe = 1'b1;
        tick();
        testCount++;
        if (rd_valid !== 1'b1 || rd_data !== expWords[0]) begin
            failCount++;
            $display("[TB] FAIL b2b_word0 got valid=%b data=%h want 1/%h", rd_valid, rd_data, expWords[0]);
        end
        // bank 1 release coincides with bank 0 last pop
        wr_strobe = 1'b0; wr_activate = 2'b00;
        for (int k = 1; k < 4; k++) begin
            tick();
            testCount++;
            if (rd_valid !== 1'b1 || rd_data !== expWords[k]) begin
                failCount++;
                $display("[TB] FAIL b2b_word%0d got valid=%b data=%h want 1/%h", k, rd_valid, rd_data, expWords[k]);
            end
        end
        rd_strobe = 1'b0;
        testCount++;
        if (rd_available !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_empty got %b want 0", rd_available); end
        tick();
    endtask

    task automatic test_overflow();
        int badWords = 0;
        logic [31:0] firstBad = '0;
        fillBank(0, 513, 32'h1000_0000);
`ifdef SDRAM_READ_PPFIFO_STATUS_EN
        testCount++;
        if (overflow !== 1'b1 || bank_count0 !== 10'd512) begin
            failCount++;
            $display("[TB] FAIL overflow_flag got ovf=%b count=%0d want 1/512", overflow, bank_count0);
        end
`endif
        rd_strobe = 1'b1;
        for (int k = 0; k < 512; k++) begin
            tick();
            if (rd_valid !== 1'b1 || rd_data !== 32'h1000_0000 + 32'(k)) begin
                if (badWords == 0) firstBad = 32'(k);
                badWords++;
            end
        end
        testCount++;
        if (badWords != 0) begin
            failCount++;
            $display("[TB] FAIL overflow_drain got %0d bad words (first index %0d) want 0", badWords, firstBad);
        end
        testCount++;
        if (rd_available !== 1'b0) begin failCount++; $display("[TB] FAIL overflow_dropped got avail=%b want 0", rd_available); end
        tick();
        testCount++;
        if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL overflow_extra_strobe got valid=%b want 0", rd_valid); end
        rd_strobe = 1'b0;
        tick();
    endtask

    task automatic test_wr_reset();
        fillBank(0, 2, 32'h70);
        wr_activate = 2'b10;
        tick();
        for (int k = 0; k < 3; k++) begin
            wr_strobe = 1'b1; wr_data = 32'h80 + 32'(k);
            tick();
        end
        testCount++;
        if (wr_ready !== 2'b00) begin failCount++; $display("[TB] FAIL flush_pre_ready got %b want 00", wr_ready); end
        wr_reset = 1'b1; rd_strobe = 1'b1; wr_data = 32'h8F;
        tick();
        wr_reset = 1'b0; wr_strobe = 1'b0; wr_activate = 2'b00;
        testCount++;
        if (wr_ready !== 2'b11 || rd_available !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL flush_state got ready=%b avail=%b want 11/0", wr_ready, rd_available);
        end
        testCount++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h1000_01FF) begin
            failCount++;
            $display("[TB] FAIL flush_rd_hold got valid=%b data=%h want 0/100001ff", rd_valid, rd_data);
        end
        tick();
        testCount++;
        if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL flush_strobe_ignored got %b want 0", rd_valid); end
        rd_strobe = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid_drain();
        fillBank(1, 4, 32'hD0);
        rd_strobe = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            testCount++;
            if (rd_data !== 32'hD0 + 32'(k)) begin
                failCount++;
                $display("[TB] FAIL mid_word%0d got %h want %h", k, rd_data, 32'hD0 + 32'(k));
            end
        end
        rst = 1'b0;
        tick();
        rst = 1'b1; rd_strobe = 1'b0;
        testCount++;
        if (rd_valid !== 1'b0 || wr_ready !== 2'b11 || rd_available !== 1'b0 || rd_data !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL mid_reset got valid=%b ready=%b avail=%b data=%h want 0/11/0/0",
                     rd_valid, wr_ready, rd_available, rd_data);
        end
        fillBank(0, 1, 32'hE0);
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        testCount++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hE0) begin
            failCount++;
            $display("[TB] FAIL mid_refill got valid=%b data=%h want 1/e0", rd_valid, rd_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_bank();
        test_order();
        test_back_to_back();
        test_overflow();
        test_wr_reset();
        test_rst_mid_drain();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
